// File: rtl/median_seq_ctrl.sv
// Sequencer that feeds a sliding 3-sample window to an external median filter and hands results downstream.
// Optional WAIT timeout watchdog is enabled by defining MEDIAN_SEQ_TIMEOUT_EN.
module median_seq_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_i,
  output logic          sample_ready_o,
  input  logic          flush_i,
  output logic          filt_en_o,
  output logic [DW-1:0] filt_d1_o,
  output logic [DW-1:0] filt_d2_o,
  output logic [DW-1:0] filt_d3_o,
  input  logic          filt_done_i,
  input  logic [DW-1:0] filt_median_i,
  output logic          med_valid_o,
  output logic [DW-1:0] med_o,
  input  logic          med_ready_i,
  output logic [15:0]   result_cnt_o,
  output logic          busy_o
`ifdef MEDIAN_SEQ_TIMEOUT_EN
  ,
  output logic          timeout_o
`endif
);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    fill_cnt;
  logic [DW-1:0] w1, w2, w3;
  logic [DW-1:0] med_q;
  logic [15:0]   res_cnt;
  logic          accept, done, deliver, expire;

  // flush_i masks every event so it wins over any simultaneous handshake.
  assign accept  = (state == S_FILL) && sample_valid_i && !flush_i;
  assign done    = (state == S_WAIT) && filt_done_i && !flush_i;
  assign deliver = (state == S_OUT) && med_ready_i && !flush_i;

`ifdef MEDIAN_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already elapsed; expiry fires on the
  // TIMEOUT-th WAIT cycle unless done arrives in that same cycle.
  assign expire = (state == S_WAIT) && !filt_done_i && !flush_i &&
                  (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (expire) timeout_o <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = S_FILL;
    end else begin
      unique case (state)
        S_FILL:  if (accept && fill_cnt >= 2'd2) state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (done)        state_nxt = S_OUT;
          else if (expire) state_nxt = S_FILL;
        end
        S_OUT:   if (deliver) state_nxt = S_FILL;
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_comb begin
    sample_ready_o = (state == S_FILL) && !flush_i;
    filt_en_o      = (state == S_ISSUE) && !flush_i;
    med_valid_o    = (state == S_OUT) && !flush_i;
    busy_o         = (state != S_FILL);
  end

  // Fill count stays at 3 after a delivered result, giving a stride-1 sliding window.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
      med_q    <= '0;
      res_cnt  <= '0;
    end else begin
      if (flush_i || expire)              fill_cnt <= '0;
      else if (accept && fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
      if (accept) begin
        w1 <= w2;
        w2 <= w3;
        w3 <= sample_i;
      end
      if (done)    med_q   <= filt_median_i;
      if (deliver) res_cnt <= res_cnt + 16'd1;
    end
  end

  assign filt_d1_o    = w1;
  assign filt_d2_o    = w2;
  assign filt_d3_o    = w3;
  assign med_o        = med_q;
  assign result_cnt_o = res_cnt;

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Directed bench for median_seq_ctrl: fill, result, backpressure, flush, WAIT timeout/hold, reset mid-OUT.
module tb_median_seq_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, sample_valid_i, flush_i, filt_done_i, med_ready_i;
  logic [DW-1:0] sample_i, filt_median_i;
  logic          sample_ready_o, filt_en_o, med_valid_o, busy_o;
  logic [DW-1:0] filt_d1_o, filt_d2_o, filt_d3_o, med_o;
  logic [15:0]   result_cnt_o;
`ifdef MEDIAN_SEQ_TIMEOUT_EN
  logic          timeout_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  median_seq_ctrl #(.DW(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .sample_valid_i(sample_valid_i), .sample_i(sample_i), .sample_ready_o(sample_ready_o),
    .flush_i(flush_i), .filt_en_o(filt_en_o),
    .filt_d1_o(filt_d1_o), .filt_d2_o(filt_d2_o), .filt_d3_o(filt_d3_o),
    .filt_done_i(filt_done_i), .filt_median_i(filt_median_i),
    .med_valid_o(med_valid_o), .med_o(med_o), .med_ready_i(med_ready_i),
    .result_cnt_o(result_cnt_o), .busy_o(busy_o)
`ifdef MEDIAN_SEQ_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_win(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    check({tag, "_d1"}, 32'(filt_d1_o), 32'(a));
    check({tag, "_d2"}, 32'(filt_d2_o), 32'(b));
    check({tag, "_d3"}, 32'(filt_d3_o), 32'(c));
  endtask

  initial begin
    rst = 1'b1; sample_valid_i = 1'b0; sample_i = '0; flush_i = 1'b0;
    filt_done_i = 1'b0; filt_median_i = '0; med_ready_i = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_ready", 32'(sample_ready_o), 1);
    check("rst_en", 32'(filt_en_o), 0);
    check("rst_mvalid", 32'(med_valid_o), 0);
    check("rst_med", 32'(med_o), 0);
    check("rst_cnt", 32'(result_cnt_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check_win("rst", 0, 0, 0);
`ifdef MEDIAN_SEQ_TIMEOUT_EN
    check("rst_timeout", 32'(timeout_o), 0);
`endif

    // Fill 1,2,3; a stray done with median 99 during FILL must be ignored
    rst = 1'b0;
    sample_valid_i = 1'b1; sample_i = 8'd1;
    tick();
    check("fill1_en", 32'(filt_en_o), 0);
    sample_i = 8'd2; filt_done_i = 1'b1; filt_median_i = 8'd99;
    tick();
    check("fill2_en", 32'(filt_en_o), 0);
    check("fill2_busy", 32'(busy_o), 0);
    sample_i = 8'd3; filt_done_i = 1'b0;
    tick();
    sample_valid_i = 1'b0;
    check("issue_en", 32'(filt_en_o), 1);
    check_win("issue", 1, 2, 3);
    check("issue_ready", 32'(sample_ready_o), 0);
    check("issue_busy", 32'(busy_o), 1);
    check("issue_med", 32'(med_o), 0);

    // Result: done 3 cycles after en, median 2
    tick();
    check("wait_en", 32'(filt_en_o), 0);
    tick();
    filt_done_i = 1'b1; filt_median_i = 8'd2;
    tick();
    filt_done_i = 1'b0; med_ready_i = 1'b1;
    check("out_valid", 32'(med_valid_o), 1);
    check("out_med", 32'(med_o), 2);
    check("out_cnt", 32'(result_cnt_o), 0);
    tick();
    med_ready_i = 1'b0;
    check("post_valid", 32'(med_valid_o), 0);
    check("post_cnt", 32'(result_cnt_o), 1);
    check("post_busy", 32'(busy_o), 0);
    sample_valid_i = 1'b1; sample_i = 8'd4;
    tick();
    sample_valid_i = 1'b0;
    check("slide_en", 32'(filt_en_o), 1);
    check_win("slide", 2, 3, 4);

    // Backpressure for 5 cycles with an upstream sample waiting
    tick();
    filt_done_i = 1'b1; filt_median_i = 8'd7;
    tick();
    filt_done_i = 1'b0; sample_valid_i = 1'b1; sample_i = 8'd55;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(med_valid_o), 1);
      check("bp_med", 32'(med_o), 7);
      check("bp_ready", 32'(sample_ready_o), 0);
      check("bp_cnt", 32'(result_cnt_o), 1);
      tick();
    end
    sample_valid_i = 1'b0; med_ready_i = 1'b1;
    check("bp_rel_valid", 32'(med_valid_o), 1);
    tick();
    med_ready_i = 1'b0;
    check("bp_done_cnt", 32'(result_cnt_o), 2);
    check("bp_done_valid", 32'(med_valid_o), 0);

    // Flush in WAIT with simultaneous done
    sample_valid_i = 1'b1; sample_i = 8'd5;
    tick();
    sample_valid_i = 1'b0;
    check_win("fl_issue", 3, 4, 5);
    tick();
    flush_i = 1'b1; filt_done_i = 1'b1; filt_median_i = 8'd77;
    check("fl_ready", 32'(sample_ready_o), 0);
    tick();
    flush_i = 1'b0; filt_done_i = 1'b0;
    check("fl_valid", 32'(med_valid_o), 0);
    check("fl_busy", 32'(busy_o), 0);
    check("fl_med", 32'(med_o), 7);
    check("fl_cnt", 32'(result_cnt_o), 2);
    sample_valid_i = 1'b1; sample_i = 8'd10;
    tick();
    check("fl_n1_en", 32'(filt_en_o), 0);
    check("fl_n1_busy", 32'(busy_o), 0);
    sample_i = 8'd11;
    tick();
    check("fl_n2_en", 32'(filt_en_o), 0);
    check("fl_n2_busy", 32'(busy_o), 0);
    sample_i = 8'd12;
    tick();
    sample_valid_i = 1'b0;
    check("fl_n3_en", 32'(filt_en_o), 1);
    check_win("fl_n3", 10, 11, 12);

    // No done: timeout build expires after 15 WAIT cycles; default build holds WAIT
`ifdef MEDIAN_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_pre", 32'(timeout_o), 0);
    check("to_pre_busy", 32'(busy_o), 1);
    tick();
    check("to_flag", 32'(timeout_o), 1);
    check("to_busy", 32'(busy_o), 0);
    check("to_cnt", 32'(result_cnt_o), 2);
    check("to_valid", 32'(med_valid_o), 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold_busy", 32'(busy_o), 1);
    end
    check("hold_valid", 32'(med_valid_o), 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("hold_exit_busy", 32'(busy_o), 0);
    check("hold_cnt", 32'(result_cnt_o), 2);
`endif

    // Reset in OUT with med_valid_o high
    sample_valid_i = 1'b1; sample_i = 8'd20;
    tick();
    sample_i = 8'd21;
    tick();
    sample_i = 8'd22;
    tick();
    sample_valid_i = 1'b0;
    check("r_issue_en", 32'(filt_en_o), 1);
    check_win("r_issue", 20, 21, 22);
    tick();
    filt_done_i = 1'b1; filt_median_i = 8'd21;
    tick();
    filt_done_i = 1'b0;
    check("r_out_valid", 32'(med_valid_o), 1);
    check("r_out_med", 32'(med_o), 21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_valid", 32'(med_valid_o), 0);
    check("r_med", 32'(med_o), 0);
    check("r_cnt", 32'(result_cnt_o), 0);
    check("r_en", 32'(filt_en_o), 0);
    check("r_busy", 32'(busy_o), 0);
    check_win("r", 0, 0, 0);
`ifdef MEDIAN_SEQ_TIMEOUT_EN
    check("r_timeout", 32'(timeout_o), 0);
`endif
    // A late done after reset is ignored, and one sample alone does not issue
    filt_done_i = 1'b1; filt_median_i = 8'd33;
    sample_valid_i = 1'b1; sample_i = 8'd40;
    tick();
    filt_done_i = 1'b0; sample_valid_i = 1'b0;
    check("late_valid", 32'(med_valid_o), 0);
    check("late_med", 32'(med_o), 0);
    check("late_en", 32'(filt_en_o), 0);
    check("late_busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_seq_ctrl.md
MEDIAN_SEQ_CTRL -- requirements
Module: median_seq_ctrl

Interface
REQ-001 Parameter DW, 8: sample and median width in bits.
REQ-002 Parameter TIMEOUT, 15: max WAIT cycles for filt_done_i, range 1..255.
REQ-003 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 sample_valid_i  in  1  upstream sample present.
REQ-007 sample_i  in  DW  upstream sample.
REQ-008 sample_ready_o  out  1  sample accepted this cycle when high with sample_valid_i.
REQ-009 flush_i  in  1  discard window and any pending result.
REQ-010 filt_en_o  out  1  one-cycle start pulse to median filter.
REQ-011 filt_d1_o / filt_d2_o / filt_d3_o  out  DW each  window: oldest / middle / newest sample.
REQ-012 filt_done_i  in  1  filter result valid.
REQ-013 filt_median_i  in  DW  filter result.
REQ-014 med_valid_o  out  1  result available downstream.
REQ-015 med_o  out  DW  captured median.
REQ-016 med_ready_i  in  1  downstream accepts result.
REQ-017 result_cnt_o  out  16  results delivered, wraps 0xFFFF->0.
REQ-018 busy_o  out  1  high in every state except FILL.

Function
REQ-019 States FILL, ISSUE, WAIT, OUT; one-hot or binary, implementer's choice.
REQ-020 FILL: sample_ready_o=1 unless flush_i; on accept, shift w1<=w2, w2<=w3, w3<=sample_i; fill count increments, saturating at 3.
REQ-021 FILL->ISSUE on the accept that makes fill count 3 (third sample, and every sample thereafter: sliding window, stride 1).
REQ-022 ISSUE: filt_en_o=1 for exactly one cycle; unconditional ->WAIT.
REQ-023 filt_d1..3_o driven from w1..w3 continuously; window registers change only on FILL accepts, so data is stable across ISSUE and WAIT.
REQ-024 WAIT: filt_done_i sampled only here (earliest the cycle after ISSUE); on done, med_o<=filt_median_i, ->OUT.
REQ-025 filt_done_i outside WAIT is ignored.
REQ-026 OUT: med_valid_o=1, med_o held stable until med_valid_o&&med_ready_i; then result_cnt_o increments, ->FILL.
REQ-027 sample_ready_o=0 in ISSUE, WAIT, OUT (backpressure upstream).
REQ-028 flush_i in any state: next state FILL, fill count 0, med_valid_o 0, filt_en_o 0; flush_i wins over simultaneous accept, done or handshake (no count increment, no capture).
REQ-029 med_ready_i high with med_valid_o low has no effect.

Reset
REQ-030 On rst: state FILL, fill count 0, w1..w3 0, med_o 0, med_valid_o 0, filt_en_o 0, result_cnt_o 0, timeout counter 0, timeout_o 0.
REQ-031 rst overrides flush_i and every handshake; reset mid-WAIT abandons the result; a late filt_done_i after reset is ignored.
REQ-032 After rst release, three new samples are required before the next filt_en_o.

Configuration
REQ-033 Macro MEDIAN_SEQ_TIMEOUT_EN: when defined, add output timeout_o (1 bit, sticky, cleared by rst only) and an 8-bit WAIT cycle counter cleared on ISSUE.
REQ-034 With MEDIAN_SEQ_TIMEOUT_EN: counter reaching TIMEOUT without filt_done_i sets timeout_o, drops the window (fill count 0), ->FILL, no result and no count increment; done in the same cycle as expiry wins.
REQ-035 Without MEDIAN_SEQ_TIMEOUT_EN: no timeout_o port, no counter; WAIT held indefinitely until filt_done_i, flush_i or rst.

Verification
REQ-036 Fill: samples 1,2,3 back-to-back after reset -> filt_en_o one cycle after 3 accepted, d1/d2/d3=1/2/3, no earlier pulse.
REQ-037 Result: filter model returns done 3 cycles after en with median 2, med_ready_i=1 -> med_valid_o one cycle, med_o=2, result_cnt_o=1; sample 4 then gives window 2/3/4.
REQ-038 Backpressure: med_ready_i=0 for 5 cycles -> med_o held at value, sample_ready_o=0 throughout, single count increment on release.
REQ-039 Flush: flush_i during WAIT plus done same cycle -> no med_valid_o, state FILL, three new samples needed before next filt_en_o.
REQ-040 Timeout (macro defined, TIMEOUT=15): no done -> timeout_o high 15 cycles after ISSUE, result_cnt_o unchanged; undefined build waits 100 cycles with busy_o=1.
REQ-041 Reset mid-OUT: rst with med_valid_o high -> next cycle all outputs at reset values, result_cnt_o=0.
